// File: rtl/pht_update_scheduler.sv
// PHT write sequencer: init sweep, then in-order update queue
// drained onto bank-conflict-free write ports.
module pht_update_scheduler #(
  parameter int WRITE_NUM       = 2,
  parameter int PHT_INDEX_WIDTH = 10,
  parameter int PHT_ENTRY_WIDTH = 2,
  parameter int BANK_NUM        = 2,
  parameter int QUEUE_DEPTH     = 8,
  parameter int INIT_VALUE      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic initStart,
  input  logic [WRITE_NUM-1:0] reqValid,
  input  logic [WRITE_NUM*PHT_INDEX_WIDTH-1:0] reqIndex,
  input  logic [WRITE_NUM*PHT_ENTRY_WIDTH-1:0] reqValue,
  output logic reqReady,
  output logic busyInit,
  output logic [$clog2(QUEUE_DEPTH):0] occupancy,
  output logic [WRITE_NUM-1:0] phtWE,
  output logic [WRITE_NUM*PHT_INDEX_WIDTH-1:0] phtWA,
  output logic [WRITE_NUM*PHT_ENTRY_WIDTH-1:0] phtWV
);

  localparam int IW = PHT_INDEX_WIDTH;
  localparam int EW = PHT_ENTRY_WIDTH;
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int BW = $clog2(BANK_NUM);
  localparam logic [IW:0] LAST = (IW+1)'((1 << IW) - 1);
  localparam logic [QW:0] ONE = (QW+1)'(1);
  localparam logic [QW:0] DEPTH = (QW+1)'(QUEUE_DEPTH);
  localparam logic [QW:0] LANES = (QW+1)'(WRITE_NUM);

  typedef enum logic {INIT, RUN} state_t;

  state_t state;
  logic [IW:0] sweepIdx;
  logic [QW-1:0] head;
  logic [QW-1:0] tail;
  logic [QW:0] count;
  logic [IW-1:0] qIdx [QUEUE_DEPTH];
  logic [EW-1:0] qVal [QUEUE_DEPTH];

  logic [QW-1:0] slot [WRITE_NUM];
  logic [QW-1:0] enqPos [WRITE_NUM];
  logic [WRITE_NUM-1:0] issue;
  logic [QW:0] numIssue;
  logic [QW:0] numEnq;
  logic blocked;
  logic ok;
  logic accept;

  // queue slots holding the oldest entries, in age order
  always_comb begin
    for (int k = 0; k < WRITE_NUM; k++) begin
      slot[k] = head + QW'(k);
    end
  end

  // strict in-order issue; first bank clash stops the cycle
  always_comb begin
    issue = '0;
    numIssue = '0;
    ok = 1'b0;
    blocked = !rst || state != RUN || initStart;
    for (int k = 0; k < WRITE_NUM; k++) begin
      ok = !blocked && (count > (QW+1)'(k));
      for (int j = 0; j < k; j++) begin
        if (qIdx[slot[j]][BW-1:0] == qIdx[slot[k]][BW-1:0]) begin
          ok = 1'b0;
        end
      end
      if (ok) begin
        issue[k] = 1'b1;
        numIssue = numIssue + ONE;
      end else begin
        blocked = 1'b1;
      end
    end
  end

  // valid lanes pack densely at tail, lane 0 first
  always_comb begin
    accept = reqReady && !initStart;
    numEnq = '0;
    for (int i = 0; i < WRITE_NUM; i++) begin
      enqPos[i] = tail + numEnq[QW-1:0];
      if (accept && reqValid[i]) begin
        numEnq = numEnq + ONE;
      end
    end
  end

  // status and write-port outputs, all forced low in reset
  always_comb begin
    busyInit = rst && state == INIT;
    occupancy = rst ? count : '0;
    reqReady = rst && state == RUN && (DEPTH - count >= LANES);
    phtWE = '0;
    phtWA = '0;
    phtWV = '0;
    if (busyInit) begin
      phtWE[0] = 1'b1;
      phtWA[IW-1:0] = sweepIdx[IW-1:0];
      phtWV[EW-1:0] = EW'(INIT_VALUE);
    end else begin
      for (int k = 0; k < WRITE_NUM; k++) begin
        if (issue[k]) begin
          phtWE[k] = 1'b1;
          phtWA[k*IW +: IW] = qIdx[slot[k]];
          phtWV[k*EW +: EW] = qVal[slot[k]];
        end
      end
    end
  end

  // sweep / run sequencing and queue pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      sweepIdx <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      unique case (state)
        INIT: begin
          if (initStart) begin
            sweepIdx <= '0;
          end else if (sweepIdx == LAST) begin
            state <= RUN;
            sweepIdx <= '0;
          end else begin
            sweepIdx <= sweepIdx + 1'b1;
          end
        end
        RUN: begin
          if (initStart) begin
            state <= INIT;
            sweepIdx <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
          end else begin
            head <= head + numIssue[QW-1:0];
            tail <= tail + numEnq[QW-1:0];
            count <= count + numEnq - numIssue;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // queue payload storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < QUEUE_DEPTH; d++) begin
        qIdx[d] <= '0;
        qVal[d] <= '0;
      end
    end else begin
      for (int i = 0; i < WRITE_NUM; i++) begin
        if (accept && reqValid[i]) begin
          qIdx[enqPos[i]] <= reqIndex[i*IW +: IW];
          qVal[enqPos[i]] <= reqValue[i*EW +: EW];
        end
      end
    end
  end

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Random-stimulus bench for pht_update_scheduler with an
// arrival-order scoreboard and a separate write-port monitor.
module tb_pht_update_scheduler;

  logic clk;
  logic rst;
  logic initStart;
  logic [1:0] reqValid;
  logic [7:0] reqIndex;
  logic [3:0] reqValue;
  logic reqReady;
  logic busyInit;
  logic [3:0] occupancy;
  logic [1:0] phtWE;
  logic [7:0] phtWA;
  logic [3:0] phtWV;

  typedef struct {
    logic [3:0] idx;
    logic [1:0] val;
  } ent_t;

  ent_t sb[$];
  int checks;
  int failures;
  int sweepExp;

  pht_update_scheduler #(
    .WRITE_NUM(2),
    .PHT_INDEX_WIDTH(4),
    .PHT_ENTRY_WIDTH(2),
    .BANK_NUM(2),
    .QUEUE_DEPTH(8),
    .INIT_VALUE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .initStart(initStart),
    .reqValid(reqValid),
    .reqIndex(reqIndex),
    .reqValue(reqValue),
    .reqReady(reqReady),
    .busyInit(busyInit),
    .occupancy(occupancy),
    .phtWE(phtWE),
    .phtWA(phtWA),
    .phtWV(phtWV)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // one request (held until taken) or one initStart pulse
  task automatic step(input logic [1:0] v,
                      input logic [3:0] i0, input logic [1:0] d0,
                      input logic [3:0] i1, input logic [1:0] d1,
                      input logic ist);
    bit done;
    int tries;
    ent_t e;
    done = 0;
    tries = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      reqValid = v;
      reqIndex = {i1, i0};
      reqValue = {d1, d0};
      initStart = ist;
      @(negedge clk);
      #2;
      if (!rst) begin
        sb.delete();
        done = 1;
      end else if (ist) begin
        if (!busyInit) sb.delete();
        done = 1;
      end else if (reqReady) begin
        if (v[0]) begin
          e.idx = i0;
          e.val = d0;
          sb.push_back(e);
        end
        if (v[1]) begin
          e.idx = i1;
          e.val = d1;
          sb.push_back(e);
        end
        done = 1;
      end else if (v == 2'b00) begin
        done = 1;
      end
      tries++;
      if (!done && tries >= 64) begin
        check("holdTimeout", tries, 0);
        done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 4'd0, 2'd0, 4'd0, 2'd0, 1'b0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    reqValid = '0;
    initStart = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // monitor: compares every cycle's outputs against the scoreboard
  initial begin
    int n;
    int expWE;
    bit clash;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rstWE", phtWE, 0);
        check("rstBusy", busyInit, 0);
        check("rstReady", reqReady, 0);
        check("rstOcc", occupancy, 0);
        sweepExp = 0;
      end else if (busyInit) begin
        check("initWE", phtWE, 1);
        check("initWA", phtWA[3:0], sweepExp);
        check("initWV", phtWV[1:0], 2);
        check("initReady", reqReady, 0);
        check("initOcc", occupancy, sb.size());
        sweepExp = initStart ? 0 : sweepExp + 1;
      end else begin
        check("sweepLen", sweepExp, 16);
        check("occ", occupancy, sb.size());
        check("ready", reqReady, (8 - sb.size() >= 2) ? 1 : 0);
        if (initStart) begin
          check("flushWE", phtWE, 0);
          sweepExp = 0;
        end else begin
          n = 0;
          while (n < 2 && n < sb.size()) begin
            clash = 0;
            for (int j = 0; j < n; j++)
              if (sb[j].idx[0] == sb[n].idx[0]) clash = 1;
            if (clash) break;
            n++;
          end
          expWE = (n == 2) ? 3 : n;
          check("runWE", phtWE, expWE);
          for (int k = 0; k < n; k++) begin
            check("runWA", phtWA[k*4 +: 4], sb[0].idx);
            check("runWV", phtWV[k*2 +: 2], sb[0].val);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int r;
    logic [1:0] v;
    logic [3:0] a;
    logic [3:0] b;
    checks = 0;
    failures = 0;
    sweepExp = 0;
    rst = 1'b0;
    initStart = 1'b0;
    reqValid = '0;
    reqIndex = '0;
    reqValue = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(18);
    step(2'b11, 4'd5, 2'd3, 4'd6, 2'd0, 1'b0);
    idle(3);
    step(2'b11, 4'd4, 2'd1, 4'd8, 2'd2, 1'b0);
    idle(3);
    for (int i = 0; i < 14; i++) begin
      a = 4'(2 * $urandom_range(0, 7));
      b = 4'(2 * $urandom_range(0, 7));
      step(2'b11, a, 2'($urandom), b, 2'($urandom), 1'b0);
    end
    step(2'b00, 4'd0, 2'd0, 4'd0, 2'd0, 1'b1);
    idle(7);
    pulseReset();
    idle(20);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 299);
      if (r == 0) begin
        pulseReset();
      end else if (r < 4) begin
        step(2'b00, 4'd0, 2'd0, 4'd0, 2'd0, 1'b1);
      end else begin
        v = 2'($urandom);
        a = 4'($urandom);
        b = 4'($urandom);
        if (r < 150) b[0] = a[0];
        step(v, a, 2'($urandom), b, 2'($urandom), 1'b0);
      end
    end
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
    check("drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
